rf_debug_port: RTL

Debug-access initiator that drives the register file's read and write ports on behalf of an external host. It accepts single-register read/write commands and a full "dump" command over a valid/ready interface. It requests a core halt before touching the register file and streams results back over a valid/ready response channel. It sits between the debug host and the register file, muxed onto the register file's rs1 read port and write port while the core is halted.

---
 rtl/rf_debug_port_if.sv | 28 ++
 rtl/rf_debug_port.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_debug_port_if.sv
// Host-side command/response channel of the register-file debug port.
// The debug port is the slave; the host (or testbench) is the master.
interface rf_debug_port_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_addr;
  logic [XLEN-1:0] cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [AW-1:0]   rsp_addr;
  logic            rsp_last;
  logic            rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
  );
endinterface

// File: rtl/rf_debug_port.sv
// Debug initiator: halts the core, then reads/writes/dumps the register file
// through its rs1 read port and write port, streaming results to the host.
module rf_debug_port #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  rf_debug_port_if.slave  dbg,
  output logic            halt_req,
  input  logic            halt_ack,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_ACCESS,
    S_RESP,
    S_RELEASE
  } state_t;

  localparam logic [1:0]    OP_READ     = 2'b00;
  localparam logic [1:0]    OP_WRITE    = 2'b01;
  localparam logic [1:0]    OP_DUMP     = 2'b10;
  localparam logic [1:0]    OP_RSVD     = 2'b11;
  localparam logic [AW-1:0] LAST_IDX    = AW'(NREG - 1);
  localparam logic [7:0]    TIMEOUT_CNT = 8'(HALT_TIMEOUT);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_op;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [AW-1:0]   r_idx;
  logic [7:0]      r_cnt;
  logic            r_halt_req;
  logic [XLEN-1:0] r_rsp_data;
  logic [AW-1:0]   r_rsp_addr;
  logic            r_rsp_last;
  logic            r_rsp_err;

  logic            w_cmd_ready;
  logic            w_cmd_fire;
  logic [7:0]      w_cnt_inc;
  logic            w_timeout;
  logic            w_wr_ok;
  logic [AW-1:0]   w_rf_raddr;
  logic            w_rf_we;
  logic [AW-1:0]   w_rf_waddr;
  logic [XLEN-1:0] w_rf_wdata;

  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_timeout = (w_cnt_inc == TIMEOUT_CNT);
  assign w_wr_ok   = (r_op == OP_WRITE) && (r_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus the register-file port, which is only driven during ACCESS.
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_cmd_fire  = 1'b0;
    w_rf_raddr  = '0;
    w_rf_we     = 1'b0;
    w_rf_waddr  = '0;
    w_rf_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = !halt_ack;
        w_cmd_fire  = dbg.cmd_valid && w_cmd_ready;
        if (w_cmd_fire) begin
          w_next = (dbg.cmd_op == OP_RSVD) ? S_RESP : S_HALT_WAIT;
        end
      end
      S_HALT_WAIT: begin
        if (halt_ack) begin
          w_next = S_ACCESS;
        end else if (w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_ACCESS: begin
        if (r_op == OP_DUMP) begin
          w_rf_raddr = r_idx;
        end else if (r_op == OP_READ) begin
          w_rf_raddr = r_addr;
        end
        if (w_wr_ok) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = r_addr;
          w_rf_wdata = r_wdata;
        end
        w_next = S_RESP;
      end
      S_RESP: begin
        if (dbg.rsp_ready) begin
          w_next = r_rsp_last ? S_RELEASE : S_ACCESS;
        end
      end
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Command latch, halt request, timeout counter and the held response beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= OP_READ;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_halt_req <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_addr <= '0;
      r_rsp_last <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_op    <= dbg.cmd_op;
            r_addr  <= dbg.cmd_addr;
            r_wdata <= dbg.cmd_wdata;
            r_idx   <= '0;
            r_cnt   <= '0;
            if (dbg.cmd_op == OP_RSVD) begin
              r_rsp_data <= '0;
              r_rsp_addr <= dbg.cmd_addr;
              r_rsp_last <= 1'b1;
              r_rsp_err  <= 1'b1;
            end else begin
              r_halt_req <= 1'b1;
            end
          end
        end
        S_HALT_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (!halt_ack && w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_addr <= r_addr;
            r_rsp_last <= 1'b1;
            r_rsp_err  <= 1'b1;
          end
        end
        S_ACCESS: begin
          case (r_op)
            OP_READ: begin
              r_rsp_data <= rf_rdata;
              r_rsp_addr <= r_addr;
              r_rsp_last <= 1'b1;
              r_rsp_err  <= 1'b0;
            end
            OP_WRITE: begin
              r_rsp_data <= w_wr_ok ? r_wdata : '0;
              r_rsp_addr <= r_addr;
              r_rsp_last <= 1'b1;
              r_rsp_err  <= !w_wr_ok;
            end
            default: begin
              r_rsp_data <= rf_rdata;
              r_rsp_addr <= r_idx;
              r_rsp_last <= (r_idx == LAST_IDX);
              r_rsp_err  <= 1'b0;
            end
          endcase
        end
        S_RESP: begin
          if (dbg.rsp_ready) begin
            if (r_rsp_last) begin
              r_halt_req <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_RELEASE: r_halt_req <= 1'b0;
        default:   r_halt_req <= 1'b0;
      endcase
    end
  end

  assign dbg.cmd_ready = w_cmd_ready && !rst;
  assign dbg.rsp_valid = (r_state == S_RESP);
  assign dbg.rsp_data  = r_rsp_data;
  assign dbg.rsp_addr  = r_rsp_addr;
  assign dbg.rsp_last  = r_rsp_last;
  assign dbg.rsp_err   = r_rsp_err;
  assign halt_req      = r_halt_req;
  assign rf_raddr      = w_rf_raddr;
  assign rf_we         = w_rf_we;
  assign rf_waddr      = w_rf_waddr;
  assign rf_wdata      = w_rf_wdata;

endmodule
